// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared types for the fetch front end:
//     - ibus request/response structs and the opcodes the predictor decodes
//     - fetch_entry_t: one buffered instruction {pc, raw_instr, pred_pc}
//     - fetch_state_t: REQ (normal fetch) / DROP (discard stale response)
//     - predict_pc(): static next-PC prediction for a fetched word
//   Optional build macro: FETCH_BTFN_EN
//     defined   -> B-type branches use backward-taken / forward-not-taken
//     undefined -> B-type branches predicted pc+4, no branch adder is built
package fetch_queue_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        u64   addr;
        logic valid;
    } ibus_req_t;

    typedef struct packed {
        u32   data;
        logic data_ok;
    } ibus_resp_t;

    typedef struct packed {
        u64 pc;
        u32 raw_instr;
        u64 pred_pc;
    } fetch_entry_t;

    typedef enum logic {
        FQ_REQ  = 1'b0,
        FQ_DROP = 1'b1
    } fetch_state_t;

    // Static prediction. JAL is always taken; JALR cannot be resolved without
    // the register file, so it falls through to pc+4 like everything else.
    // All sums wrap modulo 2^64.
    function automatic u64 predict_pc(input u64 pc, input u32 instr);
        u64 nxt;
        nxt = pc + 64'd4;
        case (instr[6:0])
            OP_JAL: nxt = pc + {{43{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
`ifdef FETCH_BTFN_EN
            // Sign bit of the B-immediate set means a backward branch,
            // which is usually a loop edge: predict taken.
            OP_B: if (instr[31])
                nxt = pc + {{51{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
`endif
            default: ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Register-based FIFO holding fetched entries for decode.
//   Ports:
//     clk, resetn      clock, asynchronous active-low reset
//     push, push_entry write an entry (ignored when full)
//     pop              consume the head entry (ignored when empty)
//     flush            clear the FIFO; wins over push and pop
//     head             entry at the read pointer, straight from registers
//     count            current occupancy
//     count_nxt        occupancy after this cycle's edge, so the owner can
//                      decide whether to launch the next request
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [159:0],
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push && (cnt_q != FULL);
        do_pop   = pop && (cnt_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign count_nxt = cnt_d;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Fetch front end: one outstanding ibus request at a time, static next-PC
//   prediction per fetched word, DEPTH-entry FIFO towards decode, and
//   redirect/flush from execute with discard of a stale in-flight response.
//   Optional build macro: FETCH_BTFN_EN (B-type backward-taken prediction).
//   Ports:
//     clk, resetn       clock, asynchronous active-low reset
//     ireq              ibus request {addr, valid}
//     iresp             ibus response {data, data_ok}
//     redirect_valid    flush queue and refetch from redirect_pc
//     redirect_pc       new fetch address (not alignment-checked)
//     out_valid         head entry valid
//     out_ready         decode accepts head entry
//     out_entry         head entry {pc, raw_instr, pred_pc}
//     count             FIFO occupancy
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    output ibus_req_t              ireq,
    input  ibus_resp_t             iresp,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output fetch_entry_t           out_entry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // pc_q doubles as the bus address: it only moves when the outstanding
    // request completes or when nothing is outstanding, so the address stays
    // stable for the whole request, including while in DROP.
    u64           pc_q, pc_d;
    u64           target_q, target_d;
    fetch_state_t state_q, state_d;
    logic         req_vld_q, req_vld_d;

    logic          done;
    logic          push, pop;
    u64            pred;
    fetch_entry_t  push_entry;
    logic [CW-1:0] count_nxt;

    assign done       = req_vld_q && iresp.data_ok;
    assign pred       = predict_pc(pc_q, iresp.data);
    assign push_entry = '{pc: pc_q, raw_instr: iresp.data, pred_pc: pred};
    assign pop        = out_valid && out_ready;

    always_comb begin
        pc_d     = pc_q;
        target_d = target_q;
        state_d  = state_q;
        push     = 1'b0;
        if (redirect_valid) begin
            // Redirect overrides everything; a response landing this same
            // cycle is already stale, so it is dropped on the spot.
            if (!req_vld_q || iresp.data_ok) begin
                pc_d    = redirect_pc;
                state_d = FQ_REQ;
            end else begin
                // Bus still owes us a response for the old address: keep the
                // request held and park the new PC until the response drains.
                state_d  = FQ_DROP;
                target_d = redirect_pc;
            end
        end else if (done) begin
            if (state_q == FQ_DROP) begin
                pc_d    = target_q;
                state_d = FQ_REQ;
            end else begin
                push = 1'b1;
                pc_d = pred;
            end
        end
    end

    // Request valid is registered from next-cycle state so a new request
    // starts the cycle after the previous one completes. A request is only
    // launched with room for its entry; occupancy cannot grow while it is
    // outstanding, so valid stays high until data_ok.
    always_comb begin
        req_vld_d = (state_d == FQ_DROP) || (count_nxt != FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            target_q  <= '0;
            state_q   <= FQ_REQ;
            req_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            target_q  <= target_d;
            state_q   <= state_d;
            req_vld_q <= req_vld_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (out_entry),
        .count      (count),
        .count_nxt  (count_nxt)
    );

    assign out_valid = (count != '0);
    assign ireq      = '{addr: pc_q, valid: req_vld_q};

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch front end. Keeps one outstanding ibus request at a time.
- Computes a static next-PC prediction for every fetched word and buffers fetched instructions, with their predicted PC, in a DEPTH-entry FIFO for decode.
- Supports redirect/flush from execute, including discard of a stale in-flight response.
- Sits between the ibus and the decode pipeline register.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 64'h8000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ireq  out  ibus_req_t  instruction bus request (addr, valid)
- iresp  in  ibus_resp_t  instruction bus response (data, data_ok)
- redirect_valid  in  1  flush queue and refetch from redirect_pc
- redirect_pc  in  64  new fetch address
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- out_entry  out  fetch_entry_t  {pc, raw_instr, pred_pc} of head entry
- count  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters

Behaviour:
- Reset (async, resetn=0): fetch pc=RESET_PC, state=REQ, FIFO empty, count=0, out_valid=0, ireq.valid=0, stored target=0.
- ireq.addr = fetch pc (or held address in DROP).
- ireq.valid=1 when state=DROP, or when state=REQ and count<DEPTH. Only one request is ever outstanding.
- Bus rule: once ireq.valid is raised, addr and valid are held stable until the cycle with data_ok=1. The request completes on that cycle's edge. data_ok may arrive in the same cycle valid rises.
- States:
  - REQ: normal fetching.
  - DROP: the outstanding response is stale and will be discarded.
- REQ, data_ok=1, no redirect:
  - Enqueue {pc, iresp.data, pred}.
  - pc <= pred.
  - Entry visible on out_valid the next cycle (1-cycle latency).
  - Next request issued the cycle after data_ok.
- Prediction pred (combinational on iresp.data):
  - JAL: pc + sext(J-imm).
  - B-type: pc+4 (see optional feature).
  - JALR and all others: pc+4.
  - All arithmetic is 64-bit, wrap-around modulo 2^64.
- Dequeue: out_valid=(count!=0). Pop when out_valid && out_ready. out_entry is the head entry, driven from registers.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Enqueue cannot occur when full, because no request is started at count=DEPTH.
- Pointers wrap modulo DEPTH.
- redirect_valid=1, applied at the clock edge and overriding everything else:
  - FIFO cleared (count=0, pointers 0). A dequeue handshake in the same cycle still counts as consumed by decode.
  - Any data_ok in the same cycle is discarded.
  - No request outstanding, or data_ok this cycle: pc <= redirect_pc, state stays REQ.
  - Request outstanding without data_ok: state <= DROP, target <= redirect_pc. Held addr/valid continue.
- DROP:
  - On data_ok: discard the data, pc <= target, state <= REQ.
  - Another redirect in DROP: target <= newest redirect_pc, stay DROP.
- Reset mid-request abandons the request immediately. The bus is assumed reset together with this block.
- redirect_pc is not alignment-checked; the low bits are passed through.

Optional Feature:
- Macro: FETCH_BTFN_EN.
- Defined: B-type prediction is backward-taken/forward-not-taken. If imm[12] (instr[31]) = 1, pred = pc + sext(B-imm); otherwise pc+4.
- Undefined: all B-type instructions predicted pc+4. The predictor logic for branches is not synthesised.
- All other behaviour is identical in both builds.

Decomposition:
- pipes package:
  - fetch_entry_t {u64 pc; u32 raw_instr; u64 pred_pc}
  - enum fetch_state_t {FQ_REQ, FQ_DROP}
  - function predict_pc(pc, instr) returning u64.
- common package: existing ibus_req_t, ibus_resp_t, OP_B, OP_JAL.
- Sub-module fetch_fifo, parametrised by DEPTH and entry type:
  - push/pop/flush interface.
  - Register-based storage with wrap pointers and count.
  - Instantiated once.

Test Plan:
- Sequential fill: reset, bus returns a non-branch word each cycle with out_ready=0 → requests at 8000_0000, _0004, _0008, _000C. ireq.valid drops when count=4. The 5th request issues the cycle after one pop.
- JAL: word 0x0100006F (jal +16) returned at pc 8000_0000 → entry pred_pc=8000_0010. Next ireq.addr=8000_0010.
- Backward branch at pc 8000_0020, beq imm=-8 (0xFE000CE3):
  - With FETCH_BTFN_EN: pred=8000_0018.
  - Without it: pred=8000_0024.
- Redirect with pending request: request to 8000_0008 outstanding, data_ok delayed 3 cycles, redirect to 8000_1000 → FIFO empty next cycle, addr held 8000_0008 until data_ok. That data is not enqueued. The next request is to 8000_1000.
- Redirect coincident with data_ok: redirect to 8000_2000 in the same cycle as data_ok → no enqueue, no DROP. The next request is to 8000_2000.
- Async reset asserted mid-DROP between edges → outputs clear immediately. After release, fetch restarts at RESET_PC.
